// File: rtl/iter_shift_32.sv
// Multi-cycle shifter: one bit position per clock for SLL/SRL/SRA/ROR,
// with a start/busy/done handshake and a held result register.
module iter_shift_32 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   num,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     work;
  logic [SHAMT_W-1:0]   cnt;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     work_step_c;

  // Single-position move of the live work register; SRA reads its current MSB.
  always_comb begin
    work_step_c = work;
    case (op_q)
      OP_SLL:  work_step_c = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_step_c = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  work_step_c = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROR:  work_step_c = {work[0], work[WIDTH-1:1]};
      default: work_step_c = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      work   <= '0;
      op_q   <= OP_SLL;
    end else begin
      done <= 1'b0;
      case (state)
        // FIN also accepts, so back-to-back operations have no idle gap.
        IDLE, FIN: begin
          if (start) begin
            work <= num;
            cnt  <= shamt;
            op_q <= op;
            if (shamt == '0) begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= num;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          work <= work_step_c;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= work_step_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_32.sv
// Randomized and directed bench for iter_shift_32 against an arithmetic
// reference model of the four shift operations and the handshake timing.
module tb_iter_shift_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] num;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int nvec = 0;
  int nerr = 0;

  iter_shift_32 #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .num    (num),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] n, input int s);
    logic [63:0] dbl;
    case (o)
      2'b00:   return n << s;
      2'b01:   return n >> s;
      2'b10:   return 32'($signed(n) >>> s);
      default: begin
        dbl = {n, n};
        return 32'(dbl >> s);
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for exactly one edge (the accepting edge).
  task automatic issue(input logic [1:0] o, input logic [31:0] n, input logic [4:0] s);
    start = 1'b1;
    op    = o;
    num   = n;
    shamt = s;
    step();
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    num   = $urandom;
    shamt = 5'($urandom_range(0, 31));
  endtask

  // Waits for done; pre = edges already elapsed since the accepting edge.
  task automatic finish_op(input logic [1:0] o, input logic [31:0] n, input logic [4:0] s,
                           input int pre, input bit hold, input string tag);
    int cyc = pre;
    int busy_cyc = 0;
    logic [31:0] exp;
    exp = model(o, n, int'(s));
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      step();
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(s));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(int'(s) - pre));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp);
    if (hold) begin
      step();
      check({tag, "_done_single"}, 32'(done), 32'd0);
      check({tag, "_result_held"}, result, exp);
    end
  endtask

  initial begin
    bit          b2b;
    logic [1:0]  ro;
    logic [31:0] rn;
    logic [4:0]  rs;
    int          pulses;

    rst = 1'b1; start = 1'b0; op = 2'b00; num = '0; shamt = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_stable", {30'd0, busy, done} | result, 32'h0);
    end

    issue(2'b00, 32'h0000_0001, 5'd4);
    finish_op(2'b00, 32'h0000_0001, 5'd4, 0, 1'b1, "sll4");
    check("sll4_abs", result, 32'h0000_0010);

    issue(2'b10, 32'h8000_0000, 5'd31);
    finish_op(2'b10, 32'h8000_0000, 5'd31, 0, 1'b1, "sra31");
    check("sra31_abs", result, 32'hFFFF_FFFF);

    issue(2'b01, 32'h8000_0000, 5'd31);
    finish_op(2'b01, 32'h8000_0000, 5'd31, 0, 1'b1, "srl31");
    check("srl31_abs", result, 32'h0000_0001);

    issue(2'b11, 32'h0000_000F, 5'd4);
    finish_op(2'b11, 32'h0000_000F, 5'd4, 0, 1'b1, "ror4");
    check("ror4_abs", result, 32'hF000_0000);

    issue(2'b01, 32'h1234_5678, 5'd0);
    finish_op(2'b01, 32'h1234_5678, 5'd0, 0, 1'b1, "zero");
    check("zero_abs", result, 32'h1234_5678);

    // Start with num=0 in the third busy cycle must be ignored.
    issue(2'b00, 32'h0000_00FF, 5'd8);
    step();
    step();
    start = 1'b1; op = 2'b00; num = 32'h0; shamt = 5'd2;
    step();
    start = 1'b0;
    finish_op(2'b00, 32'h0000_00FF, 5'd8, 3, 1'b0, "ign");
    check("ign_abs", result, 32'h0000_FF00);

    // Back-to-back start issued during the FIN cycle.
    issue(2'b10, 32'hA000_0000, 5'd1);
    check("b2b_old_held", result, 32'h0000_FF00);
    finish_op(2'b10, 32'hA000_0000, 5'd1, 0, 1'b1, "b2b");
    check("b2b_abs", result, 32'hD000_0000);

    // Reset during the second shift cycle aborts with no done pulse.
    issue(2'b00, 32'hDEAD_BEEF, 5'd10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'h0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);

    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rn = $urandom;
      rs = (i % 8 == 0) ? 5'd0 : (i % 8 == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      issue(ro, rn, rs);
      b2b = 1'($urandom_range(0, 1));
      finish_op(ro, rn, rs, 0, !b2b, "rand");
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/iter_shift_32.md
Name: iter_shift_32

Overview:
- Multi-cycle 32-bit shift unit for the ALU datapath, the sequential counterpart to the bitwise logic slices.
- Shifts one bit position per clock under a start/busy/done handshake.
- Supports logical left, logical right, arithmetic right and rotate right.
- Replaces a wide combinational barrel shifter on the shift path. The ALU result mux reads `result` when `done` pulses.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- num  input  WIDTH  operand; captured on an accepted start
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; captured on an accepted start
- busy  output  1  high while a shift is in progress
- done  output  1  one-cycle pulse; result is valid
- result  output  WIDTH  shifted value; held until the next accepted start

Behaviour:
- All logic is clocked on the rising edge of clk.
- rst has priority over every other input:
  - state <= IDLE, busy <= 0, done <= 0, result <= 0, internal count <= 0.
  - Asserting rst mid-operation aborts the shift with no done pulse.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - FIN: busy=0, done=1.
- Accept condition: start=1 while state is IDLE or FIN.
  - On accept: work register <= num, cnt <= shamt, op is latched.
  - If shamt=0, next state is FIN. Otherwise next state is SHIFT.
- SHIFT, once per cycle:
  - The work register moves one position:
    - SLL: shift left, fill 0.
    - SRL: shift right, fill 0.
    - SRA: shift right, fill with the current MSB.
    - ROR: shift right, old LSB goes to the MSB.
  - cnt decrements.
  - When cnt=1 on this edge, next state is FIN.
- FIN:
  - done=1 for exactly one cycle; result equals the work register.
  - Next state is IDLE unless a new start is accepted in that same cycle, in which case it goes to SHIFT or FIN.
- Latency, with start accepted at edge k:
  - done is visible in the cycle after edge k+shamt.
  - shamt=0 gives done one cycle after acceptance.
  - shamt=31 gives done after 32 edges.
- Busy rules:
  - busy is registered; it goes high the cycle after acceptance when shamt≠0.
  - start while busy=1 is ignored. num, shamt and op may change freely during SHIFT without effect.
- result register:
  - Updated only on entry to FIN.
  - Otherwise it keeps the last completed value, including across IDLE periods.
- Width rules:
  - SRA fill uses bit WIDTH-1 of the live work register, so sign replication accumulates correctly.
  - ROR by n equals the rotation modulo WIDTH.
  - No shift amounts ≥ WIDTH are representable.
- Back-to-back: a start in the FIN cycle is accepted. done still pulses in that cycle for the old result, and the new operation proceeds with no idle gap.

Test Plan:
- Reset check: hold rst 2 cycles, then release → busy=0, done=0, result=0x00000000; idle start=0 for 5 cycles keeps all outputs unchanged.
- SLL latency check: num=0x00000001, shamt=4, op=00, start pulse → busy=1 for 4 cycles; done pulses once with result=0x00000010, exactly 4 edges after acceptance.
- SRA sign fill: num=0x80000000, shamt=31, op=10 → result=0xFFFFFFFF after 32 edges. Repeat with op=01 → result=0x00000001.
- ROR and zero shift:
  - num=0x0000000F, shamt=4, op=11 → result=0xF0000000.
  - num=0x12345678, shamt=0, op=01 → done the next cycle with result=0x12345678 and busy never asserted.
- Ignored and back-to-back starts:
  - During a shamt=8 SLL of 0x000000FF, pulse start with num=0 at cycle 3 → ignored; result=0x0000FF00.
  - Assert start in the FIN cycle with num=0xA0000000, SRA, shamt=1 → next done gives 0xD0000000.
- Reset mid-shift: assert rst at cycle 2 of a shamt=10 shift → busy=0 and done=0 next cycle, result=0, no done pulse afterwards.
